// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: source indices,
// tag/data widths and the reserved "no producer" label.
package cdb_arbiter_pkg;

  localparam int CDB_NSRC    = 4;
  localparam int CDB_SRC_ALU = 0;
  localparam int CDB_SRC_MUL = 1;
  localparam int CDB_SRC_DIV = 2;
  localparam int CDB_SRC_LS  = 3;

  localparam int CDB_DW    = 32;
  localparam int CDB_LW    = 4;
  localparam int CDB_DEPTH = 2;

  localparam logic [CDB_LW-1:0] LABEL_NONE = 4'b0000;

  // Source index reached by stepping 'off' places past 'base', wrapping at n.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO. Full/empty come from the registered count only,
// so a push is refused while full even if the same cycle pops an entry.
module cdb_src_fifo #(
  parameter int DW    = 32,
  parameter int LW    = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          push,
  input  logic [DW-1:0] pushData,
  input  logic [LW-1:0] pushLabel,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] headData,
  output logic [LW-1:0] headLabel
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_data  [DEPTH];
  logic [LW-1:0] mem_label [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign headData  = mem_data[rd_ptr];
  assign headLabel = mem_label[rd_ptr];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr]  <= pushData;
      mem_label[wr_ptr] <= pushLabel;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Registered CDB arbiter: queues results per source and broadcasts one per
// cycle, chosen round-robin starting after the previous winner.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NSRC  = CDB_NSRC,
  parameter int DW    = CDB_DW,
  parameter int LW    = CDB_LW,
  parameter int DEPTH = CDB_DEPTH
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic [NSRC-1:0]    require,
  input  logic [NSRC*DW-1:0] dataIn,
  input  logic [NSRC*LW-1:0] labelIn,
  output logic [NSRC-1:0]    requireAC,
  output logic               BCEN,
  output logic [LW-1:0]      BClabel,
  output logic [DW-1:0]      BCdata
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;
  logic [NSRC-1:0] full;
  logic [NSRC-1:0] empty;
  logic [DW-1:0]   head_data  [NSRC];
  logic [LW-1:0]   head_label [NSRC];
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic            win_found;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    // Tag 0 marks "no producer": the handshake completes but nothing is stored.
    assign push[i]      = require[i] && requireAC[i] &&
                          (labelIn[i*LW +: LW] != LW'(LABEL_NONE));
    assign requireAC[i] = ~full[i];
    assign pop[i]       = win_found && (win_idx == IW'(i));

    cdb_src_fifo #(
      .DW   (DW),
      .LW   (LW),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .nRST     (nRST),
      .push     (push[i]),
      .pushData (dataIn[i*DW +: DW]),
      .pushLabel(labelIn[i*LW +: LW]),
      .pop      (pop[i]),
      .full     (full[i]),
      .empty    (empty[i]),
      .headData (head_data[i]),
      .headLabel(head_label[i])
    );
  end

  // Round-robin pick: first non-empty FIFO scanning upward from rr_ptr+1.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NSRC; k++) begin
      idx = rr_index(int'(rr_ptr), k, NSRC);
      if (!win_found && !empty[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  // Broadcast registers; an idle cycle drives all-zero rather than holding.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      BCEN    <= 1'b0;
      BClabel <= '0;
      BCdata  <= '0;
      rr_ptr  <= IW'(NSRC - 1);
    end else if (win_found) begin
      BCEN    <= 1'b1;
      BClabel <= head_label[win_idx];
      BCdata  <= head_data[win_idx];
      rr_ptr  <= win_idx;
    end else begin
      BCEN    <= 1'b0;
      BClabel <= '0;
      BCdata  <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table for the simple
// sequences, plus handshake-model sequences for saturation and full FIFOs.
module tb_cdb_arbiter;

  logic         clk;
  logic         nRST;
  logic [3:0]   require;
  logic [127:0] dataIn;
  logic [15:0]  labelIn;
  logic [3:0]   requireAC;
  logic         BCEN;
  logic [3:0]   BClabel;
  logic [31:0]  BCdata;

  cdb_arbiter #(.NSRC(4), .DW(32), .LW(4), .DEPTH(2)) dut (
    .clk      (clk),
    .nRST     (nRST),
    .require  (require),
    .dataIn   (dataIn),
    .labelIn  (labelIn),
    .requireAC(requireAC),
    .BCEN     (BCEN),
    .BClabel  (BClabel),
    .BCdata   (BCdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         rst_n;
    logic [3:0]   req;
    logic [15:0]  lab;
    logic [127:0] dat;
    logic         chk;
    logic [3:0]   ac;
    logic         bcen;
    logic [3:0]   bl;
    logic [31:0]  bd;
  } vec_t;

  vec_t vec [27];

  // Handshake model state: label each source currently presents, and the
  // accepted-but-not-yet-broadcast labels in acceptance order.
  logic [3:0] cur_lab [4];
  logic [3:0] sb [$];
  int acc_count;
  int bc_count;

  function automatic vec_t mk(input logic rst_n, input logic [3:0] req,
                              input logic [15:0] lab, input logic [127:0] dat,
                              input logic chk, input logic [3:0] ac,
                              input logic bcen, input logic [3:0] bl,
                              input logic [31:0] bd);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.lab = lab; v.dat = dat; v.chk = chk;
    v.ac = ac; v.bcen = bcen; v.bl = bl; v.bd = bd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Source s owns labels s*4..s*4+3 (source 0 skips label 0).
  function automatic logic [3:0] lab_first(input int s);
    return (s == 0) ? 4'd1 : 4'(s * 4);
  endfunction

  function automatic logic [3:0] lab_next(input logic [3:0] l);
    return (l[1:0] == 2'b11) ? lab_first(int'(l[3:2])) : l + 4'd1;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    nRST = 1'b0;
    require = '0;
    labelIn = '0;
    dataIn = '0;
    sb.delete();
    acc_count = 0;
    bc_count = 0;
    for (int s = 0; s < 4; s++) cur_lab[s] = lab_first(s);
  endtask

  // One cycle of the unit model: each wanting source holds its result until
  // accepted. Broadcasts are matched against the oldest pending label of
  // the same source.
  task automatic step(input logic [3:0] want, output logic [3:0] ac_s);
    int pos;
    @(posedge clk); #1;
    nRST = 1'b1;
    for (int s = 0; s < 4; s++) begin
      require[s] = want[s];
      labelIn[s*4 +: 4] = cur_lab[s];
      dataIn[s*32 +: 32] = {28'hD000000, cur_lab[s]};
    end
    @(negedge clk);
    ac_s = requireAC;
    if (BCEN) begin
      bc_count++;
      pos = -1;
      for (int j = 0; j < sb.size(); j++)
        if (pos < 0 && sb[j][3:2] == BClabel[3:2]) pos = j;
      n_tests++;
      if (pos < 0) begin
        n_fail++;
        $display("FAIL bc_unexpected: got label %0h data %0h expected none pending", BClabel, BCdata);
      end else begin
        n_tests--;
        check("bc_entry", {BClabel, BCdata}, {sb[pos], 28'hD000000, sb[pos]});
        sb.delete(pos);
      end
    end
    for (int s = 0; s < 4; s++) begin
      if (want[s] && requireAC[s]) begin
        sb.push_back(cur_lab[s]);
        cur_lab[s] = lab_next(cur_lab[s]);
        acc_count++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ac;
    logic       prev_ac0;
    logic [1:0] prev_src;
    logic [4:0] exp_ac2;

    nRST = 1'b0; require = '0; labelIn = '0; dataIn = '0;
    prev_ac0 = 1'b0; prev_src = '0;

    //             rst  req      lab        dat                                   chk  ac       bcen  bl     bd
    vec[0]  = mk(1'b0, 4'b0000, 16'h0000, 128'h0,                               1'b0, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[1]  = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[2]  = mk(1'b1, 4'b0001, 16'h0003, 128'h11,                              1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[3]  = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[4]  = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b1, 4'h3, 32'h11);
    vec[5]  = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[6]  = mk(1'b0, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[7]  = mk(1'b1, 4'b1111, 16'h4321, {32'hA3, 32'hA2, 32'hA1, 32'hA0},    1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[8]  = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[9]  = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b1, 4'h1, 32'hA0);
    vec[10] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b1, 4'h2, 32'hA1);
    vec[11] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b1, 4'h3, 32'hA2);
    vec[12] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b1, 4'h4, 32'hA3);
    vec[13] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[14] = mk(1'b1, 4'b1000, 16'h0000, {32'hDEAD, 96'h0},                    1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[15] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[16] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[17] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[18] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[19] = mk(1'b1, 4'b0011, 16'h0076, {64'h0, 32'hB1, 32'hB0},              1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[20] = mk(1'b1, 4'b0011, 16'h0098, {64'h0, 32'hC1, 32'hC0},              1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[21] = mk(1'b0, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hD, 1'b1, 4'h6, 32'hB0);
    vec[22] = mk(1'b1, 4'b0010, 16'h0050, {64'h0, 32'h55, 32'h0},               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[23] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[24] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b1, 4'h5, 32'h55);
    vec[25] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);
    vec[26] = mk(1'b1, 4'b0000, 16'h0000, 128'h0,                               1'b1, 4'hF, 1'b0, 4'h0, 32'h0);

    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #1;
      nRST    = vec[i].rst_n;
      require = vec[i].req;
      labelIn = vec[i].lab;
      dataIn  = vec[i].dat;
      @(negedge clk);
      if (vec[i].chk)
        check($sformatf("vec%0d {ac,bcen,label,data}", i),
              {23'h0, requireAC, BCEN, BClabel, BCdata},
              {23'h0, vec[i].ac, vec[i].bcen, vec[i].bl, vec[i].bd});
    end

    // Two saturating sources: alternating service and alternating accept.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(4'b0011, ac);
      if (c >= 2) begin
        check("sat_ac_one_high", {31'h0, ac[0] ^ ac[1]}, 1);
        check("sat_bcen", {31'h0, BCEN}, 1);
        if (c == 2) check("sat_first_src", {30'h0, BClabel[3:2]}, 0);
        if (c >= 3) begin
          check("sat_ac0_toggle", {31'h0, ac[0]}, {31'h0, ~prev_ac0});
          check("sat_src_alternate", {31'h0, BClabel[3:2] != prev_src}, 1);
        end
        prev_src = BClabel[3:2];
      end
      prev_ac0 = ac[0];
    end
    for (int c = 0; c < 8; c++) step(4'b0000, ac);
    check("sat_pending_left", sb.size(), 0);
    check("sat_bc_count", bc_count, acc_count);

    // Source 2 fills behind sources 0/1, is refused while full, then accepted.
    do_reset();
    exp_ac2 = 5'b10011;
    for (int c = 0; c < 5; c++) begin
      step(4'b0111, ac);
      check($sformatf("full_ac2_c%0d", c), {31'h0, ac[2]}, {31'h0, exp_ac2[c]});
    end
    for (int c = 0; c < 4; c++) step(4'b0011, ac);
    for (int c = 0; c < 10; c++) step(4'b0000, ac);
    check("full_pending_left", sb.size(), 0);
    check("full_bc_count", bc_count, acc_count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
